bla_subtractor_pipe: RTL

// - Two-stage pipelined borrow-lookahead subtractor: Diff = A - B - Bin. Subtraction counterpart of the CLA adder.
// - Stage 1 resolves the lower WIDTH/2 bits and registers the mid borrow. Stage 2 resolves the upper half.
// - Valid/ready handshake on both sides. Sits on datapath streams that need registered, full-throughput subtraction.

---
 rtl/bla_subtractor_pipe.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/bla_subtractor_pipe.sv
// ---------------------------------------------------------------------------
// bla_subtractor_pipe
//   Two-stage pipelined borrow-lookahead subtractor: Diff = A - B - Bin,
//   modulo 2^WIDTH. Stage 1 resolves the lower WIDTH/2 bits and registers the
//   mid borrow together with the upper operand halves. Stage 2 resolves the
//   upper half and drives the output register. Valid/ready on both sides gives
//   full throughput while the consumer keeps out_ready high.
//
//   Optional feature macro: SUB_OVF_EN adds the Ovf port (signed overflow),
//   registered alongside Diff/Bout.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous, active-low reset
//   in_valid   in   1      A/B/Bin valid
//   in_ready   out  1      block can accept this cycle
//   A          in   WIDTH  minuend, unsigned
//   B          in   WIDTH  subtrahend, unsigned
//   Bin        in   1      borrow in
//   out_valid  out  1      Diff/Bout (and Ovf) valid
//   out_ready  in   1      downstream accepts
//   Diff       out  WIDTH  (A - B - Bin) mod 2^WIDTH
//   Bout       out  1      unsigned borrow out (A < B + Bin)
//   Ovf        out  1      signed overflow (only with SUB_OVF_EN)
// ---------------------------------------------------------------------------
module bla_subtractor_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout
`ifdef SUB_OVF_EN
    ,
    output logic             Ovf
`endif
);

    localparam int HW = WIDTH / 2;

    generate
        if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
            $error("bla_subtractor_pipe: WIDTH must be even and >= 2");
        end
    endgenerate

    // Borrow-lookahead over one half: returns {borrow_out, diff_half}.
    function automatic logic [HW:0] sub_half(input logic [HW-1:0] a,
                                             input logic [HW-1:0] b,
                                             input logic          bin);
        logic [HW:0]   br;
        logic [HW-1:0] d;
        logic          g;
        logic          p;
        br[0] = bin;
        for (int i = 0; i < HW; i++) begin
            g       = ~a[i] & b[i];
            p       = ~(a[i] ^ b[i]);
            br[i+1] = g | (p & br[i]);
            d[i]    = a[i] ^ b[i] ^ br[i];
        end
        return {br[HW], d};
    endfunction

    // Handshake control
    logic s1_valid;
    logic rdy_en;
    logic s2_load;
    logic s1_load;
    logic accept;

    assign s2_load  = ~out_valid | out_ready;
    assign s1_load  = ~s1_valid | s2_load;
    // rdy_en keeps in_ready low through reset and re-opens on the first edge after release.
    assign in_ready = rdy_en & s1_load;
    assign accept   = in_valid & in_ready;

    // ---- stage 0 -> stage 1: lower half resolved ----
    logic [HW:0]   lo_res;
    logic [HW-1:0] diff_lo_p1;
    logic          bmid_p1;
    logic [HW-1:0] a_hi_p1;
    logic [HW-1:0] b_hi_p1;

    assign lo_res = sub_half(A[HW-1:0], B[HW-1:0], Bin);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            rdy_en   <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (s1_load) s1_valid <= accept;
        end
    end

    // Stage-1 data needs no reset: it is only observed behind s1_valid.
    always_ff @(posedge clk) begin
        if (accept) begin
            diff_lo_p1 <= lo_res[HW-1:0];
            bmid_p1    <= lo_res[HW];
            a_hi_p1    <= A[WIDTH-1:HW];
            b_hi_p1    <= B[WIDTH-1:HW];
        end
    end

    // ---- stage 1 -> stage 2: upper half resolved, output register ----
    logic [HW:0] hi_res;

    assign hi_res = sub_half(a_hi_p1, b_hi_p1, bmid_p1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            Diff      <= '0;
            Bout      <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                Diff <= {hi_res[HW-1:0], diff_lo_p1};
                Bout <= hi_res[HW];
            end
        end
    end

`ifdef SUB_OVF_EN
    // Operand MSBs ride in the registered upper halves.
    logic ovf_next;
    assign ovf_next = (a_hi_p1[HW-1] ^ b_hi_p1[HW-1]) & (a_hi_p1[HW-1] ^ hi_res[HW-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Ovf <= 1'b0;
        end else if (s2_load && s1_valid) begin
            Ovf <= ovf_next;
        end
    end
`endif

endmodule
